// File: rtl/sram_pkg.sv
// Shared types and address-split helpers for the banked SRAM array.
package sram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Low-order interleave: consecutive words land in consecutive banks.
    function automatic int unsigned bank_of(input int unsigned addr, input int unsigned banks);
        return addr % banks;
    endfunction

    function automatic int unsigned row_of(input int unsigned addr, input int unsigned banks);
        return addr / banks;
    endfunction

endpackage

// File: rtl/sram_bank.sv
// One 1R1W bank: byte-enabled write, registered read-before-write output.
module sram_bank #(
    parameter int WIDTH = 32,
    parameter int ROWS  = 16,
    parameter int RW    = 4
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [RW-1:0]      i_waddr,
    input  logic [WIDTH-1:0]   i_wdata,
    input  logic [WIDTH/8-1:0] i_wbe,
    input  logic               i_re,
    input  logic [RW-1:0]      i_raddr,
    output logic [WIDTH-1:0]   o_rdata
);

    logic [WIDTH-1:0] r_mem [ROWS];
    logic [WIDTH-1:0] r_rdata;

    // NOTE: storage has no reset; contents are cleared by the owner's INIT sweep.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int k = 0; k < WIDTH / 8; k++) begin
                if (i_wbe[k]) r_mem[i_waddr][k*8 +: 8] <= i_wdata[k*8 +: 8];
            end
        end
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_banked_array.sv
// Multi-port read, single write SRAM built from interleaved banks, with
// per-bank round-robin read arbitration, write bypass and power-up clear.
module sram_banked_array
    import sram_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 64,
    parameter int BANKS      = 4,
    parameter int READ_PORTS = 2,
    parameter int BYPASS_EN  = 1
) (
    input  logic                                       clock,
    input  logic                                       reset_n,
    input  logic [READ_PORTS-1:0]                      rd_req_valid,
    input  logic [READ_PORTS-1:0][$clog2(DEPTH)-1:0]   rd_addr,
    output logic [READ_PORTS-1:0]                      rd_req_ready,
    output logic [READ_PORTS-1:0]                      rd_rsp_valid,
    output logic [READ_PORTS-1:0][WIDTH-1:0]           rd_rsp_data,
    input  logic                                       wr_valid,
    input  logic [$clog2(DEPTH)-1:0]                   wr_addr,
    input  logic [WIDTH-1:0]                           wr_data,
    input  logic [WIDTH/8-1:0]                         wr_be,
    output logic                                       wr_ready,
    output logic                                       init_done
);

    localparam int AW   = $clog2(DEPTH);
    localparam int ROWS = DEPTH / BANKS;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int PW   = (READ_PORTS > 1) ? $clog2(READ_PORTS) : 1;
    localparam int NB   = WIDTH / 8;

    state_e                r_state;
    logic [RW-1:0]         r_init_row;
    logic [PW-1:0]         r_ptr;
    logic [READ_PORTS-1:0] r_rsp_valid;
    logic [READ_PORTS-1:0] r_byp_hit;
    logic [BW-1:0]         r_rsp_bank [READ_PORTS];
    logic [WIDTH-1:0]      r_wr_data;
    logic [NB-1:0]         r_wr_be;

    logic                  w_run;
    logic [READ_PORTS-1:0] w_req;
    logic [READ_PORTS-1:0] w_ready;
    logic [READ_PORTS-1:0] w_byp_hit;
    logic                  w_conflict;
    logic [PW-1:0]         w_next_ptr;
    logic [BANKS-1:0]      w_bank_re;
    logic [BANKS-1:0]      w_bank_we;
    logic [RW-1:0]         w_bank_raddr [BANKS];
    logic [WIDTH-1:0]      w_bank_rdata [BANKS];
    logic [BW-1:0]         w_wr_bank;
    logic [RW-1:0]         w_waddr;
    logic [WIDTH-1:0]      w_wdata;
    logic [NB-1:0]         w_wbe;

    assign w_run     = (r_state == ST_RUN);
    assign w_req     = rd_req_valid & {READ_PORTS{w_run}};
    assign w_wr_bank = BW'(bank_of(32'(wr_addr), BANKS));

    // During INIT every bank receives a full-width zero write to the sweep row.
    assign w_waddr = w_run ? RW'(row_of(32'(wr_addr), BANKS)) : r_init_row;
    assign w_wdata = w_run ? wr_data : '0;
    assign w_wbe   = w_run ? wr_be : '1;

    // Per bank: the lowest-rank requester (rank measured from r_ptr) picks the
    // row; every requester for that same address rides along.
    always_comb begin
        int               best_rank;
        int               rank;
        int               win;
        logic [AW-1:0]    win_addr;
        logic             clash;
        // NOTE: every output gets a default first so no path can infer a latch.
        w_ready    = '0;
        w_bank_re  = '0;
        w_conflict = 1'b0;
        w_next_ptr = r_ptr;
        best_rank  = READ_PORTS;
        rank       = 0;
        win        = 0;
        win_addr   = '0;
        clash      = 1'b0;
        for (int b = 0; b < BANKS; b++) begin
            w_bank_raddr[b] = '0;
            best_rank       = READ_PORTS;
            win             = 0;
            win_addr        = '0;
            clash           = 1'b0;
            for (int p = 0; p < READ_PORTS; p++) begin
                rank = (p >= int'(r_ptr)) ? p - int'(r_ptr) : p + READ_PORTS - int'(r_ptr);
                if (w_req[p] && bank_of(32'(rd_addr[p]), BANKS) == b && rank < best_rank) begin
                    best_rank = rank;
                    win       = p;
                    win_addr  = rd_addr[p];
                end
            end
            if (best_rank < READ_PORTS) begin
                w_bank_re[b]    = 1'b1;
                w_bank_raddr[b] = RW'(row_of(32'(win_addr), BANKS));
                for (int p = 0; p < READ_PORTS; p++) begin
                    if (w_req[p] && bank_of(32'(rd_addr[p]), BANKS) == b) begin
                        if (rd_addr[p] == win_addr) w_ready[p] = 1'b1;
                        else                        clash      = 1'b1;
                    end
                end
                if (clash && !w_conflict) begin
                    w_conflict = 1'b1;
                    w_next_ptr = (win == READ_PORTS - 1) ? '0 : PW'(win + 1);
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < READ_PORTS; p++) begin
            w_byp_hit[p] = (BYPASS_EN != 0) && w_run && wr_valid && w_ready[p]
                           && (rd_addr[p] == wr_addr);
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        assign w_bank_we[b] = !w_run || (wr_valid && w_wr_bank == BW'(b));

        sram_bank #(
            .WIDTH (WIDTH),
            .ROWS  (ROWS),
            .RW    (RW)
        ) u_bank (
            .i_clk   (clock),
            .i_we    (w_bank_we[b]),
            .i_waddr (w_waddr),
            .i_wdata (w_wdata),
            .i_wbe   (w_wbe),
            .i_re    (w_bank_re[b]),
            .i_raddr (w_bank_raddr[b]),
            .o_rdata (w_bank_rdata[b])
        );
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_INIT;
            r_init_row  <= '0;
            r_ptr       <= '0;
            r_rsp_valid <= '0;
            r_byp_hit   <= '0;
            r_wr_data   <= '0;
            r_wr_be     <= '0;
            for (int p = 0; p < READ_PORTS; p++) r_rsp_bank[p] <= '0;
        end else begin
            if (r_state == ST_INIT) begin
                r_init_row <= r_init_row + RW'(1);
                if (r_init_row == RW'(ROWS - 1)) r_state <= ST_RUN;
            end
            if (w_conflict) r_ptr <= w_next_ptr;
            r_rsp_valid <= w_ready;
            r_byp_hit   <= w_byp_hit;
            r_wr_data   <= wr_data;
            r_wr_be     <= wr_be;
            for (int p = 0; p < READ_PORTS; p++) begin
                r_rsp_bank[p] <= BW'(bank_of(32'(rd_addr[p]), BANKS));
            end
        end
    end

    // Bank output is the pre-write word; a forwarded write is merged on top.
    always_comb begin
        logic [WIDTH-1:0] word;
        word        = '0;
        rd_rsp_data = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            word = w_bank_rdata[r_rsp_bank[p]];
            for (int k = 0; k < NB; k++) begin
                if (r_byp_hit[p] && r_wr_be[k]) word[k*8 +: 8] = r_wr_data[k*8 +: 8];
            end
            rd_rsp_data[p] = r_rsp_valid[p] ? word : '0;
        end
    end

    assign rd_req_ready = w_ready;
    assign rd_rsp_valid = r_rsp_valid;
    assign wr_ready     = w_run;
    assign init_done    = w_run;

endmodule

// File: tb/tb_sram_banked_array.sv
// Bench for sram_banked_array: directed scenarios plus random traffic checked
// against a flat-array reference model, for both bypass settings side by side.
module tb_sram_banked_array;

    localparam int W  = 32;
    localparam int D  = 64;
    localparam int B  = 4;
    localparam int NP = 2;
    localparam int AW = 6;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic [NP-1:0]          rd_req_valid;
    logic [NP-1:0][AW-1:0]  rd_addr;
    logic                   wr_valid;
    logic [AW-1:0]          wr_addr;
    logic [W-1:0]           wr_data;
    logic [W/8-1:0]         wr_be;

    logic [NP-1:0]          rd_req_ready, rd_req_ready_nb;
    logic [NP-1:0]          rd_rsp_valid, rd_rsp_valid_nb;
    logic [NP-1:0][W-1:0]   rd_rsp_data, rd_rsp_data_nb;
    logic                   wr_ready, wr_ready_nb;
    logic                   init_done, init_done_nb;

    int n_cmp = 0;
    int n_mis = 0;

    logic [W-1:0]  ref_mem [D];
    int            ptr;
    int            init_left;
    logic [NP-1:0] exp_v;
    logic [W-1:0]  exp_d  [NP];
    logic [W-1:0]  exp_dn [NP];

    always #5 clock = ~clock;

    sram_banked_array #(
        .WIDTH(W), .DEPTH(D), .BANKS(B), .READ_PORTS(NP), .BYPASS_EN(1)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .rd_req_valid(rd_req_valid), .rd_addr(rd_addr), .rd_req_ready(rd_req_ready),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .wr_ready(wr_ready), .init_done(init_done)
    );

    sram_banked_array #(
        .WIDTH(W), .DEPTH(D), .BANKS(B), .READ_PORTS(NP), .BYPASS_EN(0)
    ) dut_nb (
        .clock(clock), .reset_n(reset_n),
        .rd_req_valid(rd_req_valid), .rd_addr(rd_addr), .rd_req_ready(rd_req_ready_nb),
        .rd_rsp_valid(rd_rsp_valid_nb), .rd_rsp_data(rd_rsp_data_nb),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .wr_ready(wr_ready_nb), .init_done(init_done_nb)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] nw,
                                           input logic [W/8-1:0] be);
        logic [W-1:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    // One clock cycle: check last cycle's responses, drive new inputs, check
    // acceptance, then advance the model past the rising edge.
    task automatic cycle(input logic [NP-1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic wv, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                         input logic [W/8-1:0] be);
        logic [AW-1:0] a [NP];
        logic [NP-1:0] exp_rdy;
        logic          running;
        logic          refused;
        logic          conflict;
        int            q;
        @(negedge clock);
        running = (init_left == 0);
        for (int p = 0; p < NP; p++) begin
            check($sformatf("rsp_valid[%0d]", p), 64'(rd_rsp_valid[p]), 64'(exp_v[p]));
            check($sformatf("rsp_data[%0d]", p), 64'(rd_rsp_data[p]), 64'(exp_v[p] ? exp_d[p] : '0));
            check($sformatf("nb_rsp_valid[%0d]", p), 64'(rd_rsp_valid_nb[p]), 64'(exp_v[p]));
            check($sformatf("nb_rsp_data[%0d]", p), 64'(rd_rsp_data_nb[p]), 64'(exp_v[p] ? exp_dn[p] : '0));
        end
        check("init_done", 64'(init_done), 64'(running));
        check("nb_init_done", 64'(init_done_nb), 64'(running));

        rd_req_valid = v;
        rd_addr[0]   = a0;
        rd_addr[1]   = a1;
        wr_valid     = wv;
        wr_addr      = wa;
        wr_data      = wd;
        wr_be        = be;
        #1;

        a[0] = a0;
        a[1] = a1;
        exp_rdy = '0;
        // A port is refused only by a higher-priority port hitting the same bank at another word.
        for (int p = 0; p < NP; p++) begin
            q = 1 - p;
            refused = v[q] && (a[q] % B == a[p] % B) && (a[q] != a[p])
                      && ((q + NP - ptr) % NP < (p + NP - ptr) % NP);
            exp_rdy[p] = running && v[p] && !refused;
        end
        conflict = running && (v == 2'b11) && (a0 % B == a1 % B) && (a0 != a1);
        check("rd_req_ready", 64'(rd_req_ready), 64'(exp_rdy));
        check("nb_rd_req_ready", 64'(rd_req_ready_nb), 64'(exp_rdy));
        check("wr_ready", 64'(wr_ready), 64'(running));

        for (int p = 0; p < NP; p++) begin
            exp_v[p]  = exp_rdy[p];
            exp_dn[p] = ref_mem[a[p]];
            exp_d[p]  = (running && wv && wa == a[p]) ? merge(ref_mem[a[p]], wd, be) : ref_mem[a[p]];
        end
        if (running && wv) ref_mem[wa] = merge(ref_mem[wa], wd, be);
        if (conflict) ptr = (ptr + 1) % NP;

        @(posedge clock);
        if (init_left > 0) init_left--;
    endtask

    // Called right after a rising edge: asserts reset mid-cycle, holds it, releases.
    task automatic do_reset();
        #1;
        check("pre_reset_rsp_valid", 64'(rd_rsp_valid), 64'(exp_v));
        #1;
        reset_n      = 1'b0;
        rd_req_valid = '0;
        wr_valid     = 1'b0;
        #1;
        check("reset_rsp_valid", 64'(rd_rsp_valid), 64'(0));
        check("reset_rsp_data", 64'(rd_rsp_data), 64'(0));
        check("reset_init_done", 64'(init_done), 64'(0));
        exp_v     = '0;
        ptr       = 0;
        init_left = D / B;
        for (int i = 0; i < D; i++) ref_mem[i] = '0;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] ra0, ra1, rwa;
        reset_n      = 1'b1;
        rd_req_valid = '0;
        rd_addr      = '0;
        wr_valid     = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        wr_be        = '0;
        exp_v        = '0;
        #1 reset_n = 1'b0;
        @(posedge clock);
        do_reset();

        // Reads through INIT are refused; afterwards every word reads zero.
        for (int i = 0; i < 24; i++) begin
            ra0 = 6'($urandom_range(D - 1));
            cycle(2'($urandom_range(3)), ra0, ra0 ^ 6'd1, 1'b0, '0, '0, '0);
        end

        cycle(2'b00, '0, '0, 1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
        cycle(2'b00, '0, '0, 1'b1, 6'd5, 32'h000000AA, 4'h1);
        cycle(2'b01, 6'd5, '0, 1'b1, 6'd5, 32'hFFFFFFFF, 4'h0);
        cycle(2'b10, '0, 6'd5, 1'b0, '0, '0, '0);

        cycle(2'b11, 6'd4, 6'd8, 1'b0, '0, '0, '0);
        cycle(2'b10, '0, 6'd8, 1'b0, '0, '0, '0);

        cycle(2'b00, '0, '0, 1'b1, 6'd7, 32'hCAFEF00D, 4'hF);
        cycle(2'b11, 6'd7, 6'd7, 1'b0, '0, '0, '0);

        cycle(2'b01, 6'd3, '0, 1'b1, 6'd3, 32'h12345678, 4'hF);
        cycle(2'b10, '0, 6'd3, 1'b1, 6'd3, 32'h00AB0000, 4'h4);
        cycle(2'b01, 6'd3, '0, 1'b0, '0, '0, '0);

        for (int i = 0; i < 400; i++) begin
            ra0 = 6'($urandom_range(D - 1));
            ra1 = ($urandom_range(3) == 0) ? ra0 : 6'($urandom_range(D - 1));
            rwa = ($urandom_range(2) == 0) ? ra0 : 6'($urandom_range(D - 1));
            cycle(2'($urandom_range(3)), ra0, ra1, 1'($urandom_range(1)), rwa, $urandom,
                  4'($urandom_range(15)));
        end

        // Reset while a response is in flight, then exercise the re-cleared array.
        cycle(2'b01, 6'd9, '0, 1'b0, '0, '0, '0);
        do_reset();
        for (int i = 0; i < 120; i++) begin
            ra0 = 6'($urandom_range(D - 1));
            ra1 = ($urandom_range(3) == 0) ? ra0 : 6'($urandom_range(D - 1));
            rwa = ($urandom_range(2) == 0) ? ra1 : 6'($urandom_range(D - 1));
            cycle(2'($urandom_range(3)), ra0, ra1, 1'($urandom_range(1)), rwa, $urandom,
                  4'($urandom_range(15)));
        end
        cycle(2'b00, '0, '0, 1'b0, '0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
